// File: rtl/fifo_uart_tx_if.sv
// Read port of bram_fifo as seen by the consumer that drains it.
// Latency: fifo_rd_data is valid the cycle after fifo_rd_en; the interface has no storage.
// Backpressure: the consumer pops only while fifo_empty is low; there is no ready signal toward the FIFO.
//
// Signals:
//   fifo_rd_en    consumer -> FIFO, single-cycle pop strobe
//   fifo_rd_data  FIFO -> consumer, read data
//   fifo_empty    FIFO -> consumer, empty flag
// Modports: master = consumer (fifo_uart_tx), slave = FIFO side.
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_empty;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_data,
    input  fifo_empty
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_data,
    output fifo_empty
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains bytes from a bram_fifo read port and sends each one as a UART frame on tx (8N1 by default).
// Latency: tx falls on the 3rd edge, counting the IDLE edge that sees en=1 and a non-empty FIFO.
// Backpressure: pops only while fifo_empty=0, one byte per frame; en gates only the start of a new frame.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   en           drain enable, looked at only when a new frame could start
//   fifo         fifo_uart_tx_if.master: fifo_rd_en out, fifo_rd_data / fifo_empty in
//   tx           serial line, idles high
//   busy         high in every state except IDLE
//   tx_done      one-cycle pulse on the last cycle of the stop bit
//   frame_count  frames completed since reset, wraps silently
//
// Build option: define FIFO_UART_TX_PARITY_EN to add a parity bit between the data bits and the stop bit.
//   The parity bit is even when PARITY_ODD=0 and odd when PARITY_ODD=1. Without the macro, PARITY_ODD has no effect.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_ODD   = 0,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  fifo_uart_tx_if.master       fifo,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done,
  output logic [CNT_WIDTH-1:0] frame_count
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  // A single-cycle bit cannot be told apart from the stop-bit pulse logic.
  if (CLKS_PER_BIT < 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
    $error("fifo_uart_tx: CLKS_PER_BIT must be >= 2 and PARITY_ODD must be 0 or 1");
  end

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LOAD, S_START, S_DATA, S_STOP
  } state_t;
`endif

  state_t                state, state_nxt;
  logic [BAUD_W-1:0]     baud_cnt, baud_nxt;
  logic [BIT_W-1:0]      bit_cnt, bit_nxt;
  logic [DATA_WIDTH-1:0] data_q, data_nxt;
  logic                  rd_en_q;
  logic                  tx_nxt;
  logic                  rd_en_nxt;
  logic                  busy_nxt;
  logic                  tx_done_nxt;
  logic                  bit_end;
  logic                  can_start;

  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign can_start = en && !fifo.fifo_empty;

  assign fifo.fifo_rd_en = rd_en_q;

`ifdef FIFO_UART_TX_PARITY_EN
  localparam logic PAR_SENSE = (PARITY_ODD != 0);
  logic parity_bit;
  // The byte stays in data_q for the whole frame, so parity is a plain XOR reduction.
  assign parity_bit = (^data_q) ^ PAR_SENSE;
`endif

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    data_nxt  = data_q;

    case (state)
      S_IDLE: begin
        if (can_start) begin
          state_nxt = S_READ;
        end
      end

      S_READ: begin
        state_nxt = S_LOAD;
      end

      // The FIFO presents the popped byte during this cycle.
      S_LOAD: begin
        state_nxt = S_START;
        data_nxt  = fifo.fifo_rd_data;
        baud_nxt  = '0;
        bit_nxt   = '0;
      end

      S_START: begin
        if (bit_end) begin
          state_nxt = S_DATA;
          baud_nxt  = '0;
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          baud_nxt = '0;
          if (bit_cnt == BIT_LAST) begin
            bit_nxt = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            state_nxt = S_PARITY;
`else
            state_nxt = S_STOP;
`endif
          end else begin
            bit_nxt = bit_cnt + 1'b1;
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end

`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_nxt = S_STOP;
          baud_nxt  = '0;
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
`endif

      // Going straight to READ is what gives the CLKS_PER_BIT+2 high gap between back-to-back frames.
      S_STOP: begin
        if (bit_end) begin
          baud_nxt  = '0;
          state_nxt = can_start ? S_READ : S_IDLE;
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = S_IDLE;
        baud_nxt  = '0;
        bit_nxt   = '0;
      end
    endcase

    // All outputs are registered, so they are decoded from the next state.
    tx_nxt = 1'b1;
    case (state_nxt)
      S_START:  tx_nxt = 1'b0;
      S_DATA:   tx_nxt = data_nxt[bit_nxt];
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: tx_nxt = parity_bit;
`endif
      default:  tx_nxt = 1'b1;
    endcase

    // READ is entered only from a decision that saw fifo_empty=0.
    rd_en_nxt = (state_nxt == S_READ);
    busy_nxt  = (state_nxt != S_IDLE);
    // The baud counter is 0 on the first STOP cycle, so this fires only on the last STOP cycle.
    tx_done_nxt = (state_nxt == S_STOP) && (baud_nxt == BAUD_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      data_q      <= '0;
      tx          <= 1'b1;
      rd_en_q     <= 1'b0;
      busy        <= 1'b0;
      tx_done     <= 1'b0;
      frame_count <= '0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      data_q   <= data_nxt;
      tx       <= tx_nxt;
      rd_en_q  <= rd_en_nxt;
      busy     <= busy_nxt;
      tx_done  <= tx_done_nxt;
      if (tx_done_nxt) begin
        frame_count <= frame_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx: behavioural 1-cycle-latency FIFO, UART decoder and byte scoreboard.
// Inputs are driven 1 time unit after posedge; the monitors sample on negedge.
// CLKS_PER_BIT=4, CNT_WIDTH=3 so frame_count wraps within the run.
module tb_fifo_uart_tx;
  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int CW  = 3;
  localparam int POD = 0;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int FRAME_BITS = DW + 3;
`else
  localparam int FRAME_BITS = DW + 2;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic          tx, busy, tx_done;
  logic [CW-1:0] frame_count;

  fifo_uart_tx_if #(.DATA_WIDTH(DW)) fif ();

  fifo_uart_tx #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB),
    .PARITY_ODD  (POD),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo       (fif),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural FIFO: pop on rd_en and present the data the next cycle; the empty flag is registered.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];

  always @(posedge clk) begin
    if (fif.fifo_rd_en && fifo_q.size() > 0) fif.fifo_rd_data <= fifo_q.pop_front();
    fif.fifo_empty <= (fifo_q.size() == 0);
  end

  // Negedge monitor: read strobes, tx_done, and the UART decoder feeding the scoreboard.
  int            cyc = 0;
  int            rd_pulses = 0;
  int            done_cnt = 0;
  int            rx_frames = 0;
  logic          prev_rd = 1'b0;
  logic          rx_act = 1'b0;
  int            rx_cyc = 0;
  int            rx_bit = 0;
  logic [DW-1:0] rx_byte = '0;
  logic [DW-1:0] exp_byte;
  logic          after_frame = 1'b0;
  int            gap_cnt = 0;
  int            fall_cyc = 0;
  int            gap_q[$];

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      rx_act      = 1'b0;
      after_frame = 1'b0;
    end else begin
      if (fif.fifo_rd_en) begin
        if (!prev_rd) rd_pulses++;
        check_eq("rd_on_empty", fif.fifo_empty, 0);
        check_eq("rd_single_cycle", prev_rd, 0);
      end
      if (tx_done) begin
        done_cnt++;
        check_eq("frame_len", cyc - fall_cyc + 1, FRAME_CYC);
      end
      if (!rx_act) begin
        if (tx == 1'b0) begin
          if (after_frame && gap_cnt <= 20) gap_q.push_back(gap_cnt);
          after_frame = 1'b0;
          rx_act      = 1'b1;
          rx_cyc      = 0;
          fall_cyc    = cyc;
        end else if (after_frame) begin
          gap_cnt++;
        end
      end else begin
        rx_cyc++;
        if (rx_cyc % CPB == CPB / 2) begin
          rx_bit = rx_cyc / CPB;
          if (rx_bit == 0) begin
            check_eq("start_bit", tx, 0);
          end else if (rx_bit <= DW) begin
            rx_byte[rx_bit-1] = tx;
`ifdef FIFO_UART_TX_PARITY_EN
          end else if (rx_bit == DW + 1) begin
            if (exp_q.size() > 0) begin
              exp_byte = exp_q[0];
              check_eq("parity_bit", tx, (^exp_byte) ^ (POD != 0));
            end
`endif
          end else begin
            check_eq("stop_bit", tx, 1);
            if (exp_q.size() == 0) begin
              check_eq("rx_unexpected_frame", exp_q.size(), 1);
            end else begin
              exp_byte = exp_q.pop_front();
              check_eq("rx_byte", rx_byte, exp_byte);
            end
            rx_frames++;
            rx_act      = 1'b0;
            after_frame = 1'b1;
            gap_cnt     = CPB / 2 + 1;  // stop-bit cycles already seen high
          end
        end
      end
    end
    prev_rd = fif.fifo_rd_en;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [DW-1:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic wait_rx(input int target, input string tag);
    int k;
    k = 0;
    while ((rx_frames < target || busy) && k < 2000) begin
      tick(1);
      k++;
    end
    if (k >= 2000) check_eq({tag, "_timeout"}, rx_frames, target);
  endtask

  task automatic wait_tx_low(input string tag);
    int k;
    k = 0;
    while (tx === 1'b1 && k < 200) begin
      tick(1);
      k++;
    end
    if (k >= 200) check_eq({tag, "_tx_low_timeout"}, tx, 0);
  endtask

  int exp_fc = 0;
  int exp_frames = 0;
  int exp_reads = 0;
  int lat, t1_low, t1_busy, rd0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    en  = 1'b0;
    tick(3);
    check_eq("rst_tx", tx, 1);
    check_eq("rst_rd_en", fif.fifo_rd_en, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_tx_done", tx_done, 0);
    check_eq("rst_frame_count", frame_count, 0);
    rst = 1'b0;

    // 1: enabled with an empty FIFO, nothing may happen
    en = 1'b1;
    t1_low = 0; t1_busy = 0; rd0 = rd_pulses;
    repeat (100) begin
      tick(1);
      if (tx !== 1'b1) t1_low++;
      if (busy !== 1'b0) t1_busy++;
    end
    check_eq("t1_tx_low_cycles", t1_low, 0);
    check_eq("t1_busy_cycles", t1_busy, 0);
    check_eq("t1_rd_pulses", rd_pulses - rd0, 0);
    check_eq("t1_frame_count", frame_count, 0);

    // 2: single byte 0xA5; tx falls on the 3rd edge after en rises (READ, LOAD, START)
    en = 1'b0;
    push_byte(8'hA5);
    tick(3);
    en = 1'b1;
    lat = 0;
    while (tx === 1'b1 && lat < 20) begin
      tick(1);
      lat++;
    end
    check_eq("t2_latency", lat, 3);
    exp_frames += 1; exp_reads += 1; exp_fc = (exp_fc + 1) % 8;
    wait_rx(exp_frames, "t2");
    check_eq("t2_frame_count", frame_count, exp_fc);
    check_eq("t2_tx_done_cnt", done_cnt, exp_frames);
    check_eq("t2_rd_pulses", rd_pulses, exp_reads);
    check_eq("t2_fifo_left", fifo_q.size(), 0);
    check_eq("t2_busy", busy, 0);

    // 3: four back-to-back frames with a stop+2 cycle high gap between them
    en = 1'b0;
    push_byte(8'h00); push_byte(8'hFF); push_byte(8'h3C); push_byte(8'h81);
    tick(30);
    gap_q.delete();
    en = 1'b1;
    exp_frames += 4; exp_reads += 4; exp_fc = (exp_fc + 4) % 8;
    wait_rx(exp_frames, "t3");
    check_eq("t3_rd_pulses", rd_pulses, exp_reads);
    check_eq("t3_frame_count", frame_count, exp_fc);
    check_eq("t3_gap_count", gap_q.size(), 3);
    foreach (gap_q[i]) check_eq("t3_gap_len", gap_q[i], CPB + 2);
    check_eq("t3_busy", busy, 0);

    // 4: en dropped during DATA: first frame finishes, second byte stays queued
    en = 1'b0;
    push_byte(8'hC3); push_byte(8'h96);
    tick(3);
    en = 1'b1;
    wait_tx_low("t4");
    tick(12);
    en = 1'b0;
    exp_frames += 1; exp_reads += 1; exp_fc = (exp_fc + 1) % 8;
    wait_rx(exp_frames, "t4");
    tick(20);
    check_eq("t4_rd_pulses", rd_pulses, exp_reads);
    check_eq("t4_fifo_left", fifo_q.size(), 1);
    check_eq("t4_busy", busy, 0);
    check_eq("t4_frame_count", frame_count, exp_fc);

    // 5: reset in the middle of DATA: 0x96 is dropped and 0x5A follows cleanly.
    //    Reset clears frame_count, and the aborted frame is never counted.
    push_byte(8'h5A);
    en = 1'b1;
    wait_tx_low("t5");
    exp_reads += 1;
    tick(10);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    void'(exp_q.pop_front());
    check_eq("t5_tx_after_rst", tx, 1);
    check_eq("t5_busy_after_rst", busy, 0);
    check_eq("t5_fc_after_rst", frame_count, 0);
    check_eq("t5_rd_en_after_rst", fif.fifo_rd_en, 0);
    exp_fc = 0;
    exp_frames += 1; exp_reads += 1; exp_fc = (exp_fc + 1) % 8;
    wait_rx(exp_frames, "t5");
    check_eq("t5_frame_count", frame_count, exp_fc);
    check_eq("t5_rd_pulses", rd_pulses, exp_reads);
    check_eq("t5_fifo_left", fifo_q.size(), 0);

`ifdef FIFO_UART_TX_PARITY_EN
    // 6: 0x07 carries an even parity bit of 1; the frame is 11 bits long
    push_byte(8'h07);
    exp_frames += 1; exp_reads += 1; exp_fc = (exp_fc + 1) % 8;
    wait_rx(exp_frames, "t6");
    check_eq("t6_frame_count", frame_count, exp_fc);
`endif

    // 7: eight more frames wrap the 3-bit frame_count back to its value before the burst
    en = 1'b0;
    for (int i = 0; i < 8; i++) push_byte(8'($urandom_range(0, 255)));
    tick(3);
    en = 1'b1;
    exp_frames += 8; exp_reads += 8; exp_fc = (exp_fc + 8) % 8;
    wait_rx(exp_frames, "t7");
    check_eq("t7_frame_count_wrap", frame_count, exp_fc);
    check_eq("t7_rd_pulses", rd_pulses, exp_reads);

    // Closing totals
    tick(5);
    check_eq("end_tx_done_cnt", done_cnt, exp_frames);
    check_eq("end_rx_frames", rx_frames, exp_frames);
    check_eq("end_scoreboard_left", exp_q.size(), 0);
    check_eq("end_tx_idle", tx, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
